// File: rtl/median_pkg.sv
// rtl/median_pkg.sv - shared constants for the median sequencer slice
//
// Purpose : default window geometry, FSM state encoding and helpers that
//           derive the counter widths from NB_PIXEL.
// Ports   : none (package).
package median_pkg;

    localparam int SIZE_DEF     = 8;
    localparam int NB_PIXEL_DEF = 9;

    localparam int ST_W = 2;
    localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
    localparam logic [ST_W-1:0] ST_LOAD = 2'd1;
    localparam logic [ST_W-1:0] ST_PASS = 2'd2;
    localparam logic [ST_W-1:0] ST_DONE = 2'd3;

    // Pixel/cycle counter must reach NB_PIXEL without wrapping.
    function automatic int cyc_cnt_w(input int nb);
        return $clog2(nb + 1);
    endfunction

    // Pass counter must reach NB_PIXEL/2 without wrapping.
    function automatic int pass_cnt_w(input int nb);
        return $clog2(nb / 2 + 1);
    endfunction

endpackage

// File: rtl/med.sv
// rtl/med.sv - MED sorting datapath driven by median_seq
//
// Purpose : NB_PIXEL-deep register chain. DSI=1 shifts DI in. DSI=0, BYP=1
//           rotates the whole chain. DSI=0, BYP=0 keeps the larger of the
//           last two stages in the last stage and recirculates the smaller.
// Ports   : CLK clock; DI pixel in; DSI shift-in select; BYP bypass
//           compare; DO last stage.
module med #(
    parameter int SIZE     = 8,
    parameter int NB_PIXEL = 9
) (
    input  logic            CLK,
    input  logic [SIZE-1:0] DI,
    input  logic            DSI,
    input  logic            BYP,
    output logic [SIZE-1:0] DO
);

    logic [SIZE-1:0] r_q [NB_PIXEL];
    logic [SIZE-1:0] hi;
    logic [SIZE-1:0] lo;

    always_comb begin
        hi = r_q[NB_PIXEL-1];
        lo = r_q[NB_PIXEL-2];
        if (r_q[NB_PIXEL-2] > r_q[NB_PIXEL-1]) begin
            hi = r_q[NB_PIXEL-2];
            lo = r_q[NB_PIXEL-1];
        end
    end

    // Contents are don't-care after reset, so the chain carries no reset.
    always_ff @(posedge CLK) begin
        for (int i = 1; i < NB_PIXEL - 1; i++) begin
            r_q[i] <= r_q[i-1];
        end
        if (DSI) begin
            r_q[0]          <= DI;
            r_q[NB_PIXEL-1] <= r_q[NB_PIXEL-2];
        end else if (BYP) begin
            r_q[0]          <= r_q[NB_PIXEL-1];
            r_q[NB_PIXEL-1] <= r_q[NB_PIXEL-2];
        end else begin
            r_q[0]          <= lo;
            r_q[NB_PIXEL-1] <= hi;
        end
    end

    assign DO = r_q[NB_PIXEL-1];

endmodule

// File: rtl/median_seq_cnt.sv
// rtl/median_seq_cnt.sv - load/pass counter pair and compare decision
//
// Purpose : counts load beats, then PASS cycles and passes; flags the
//           last load beat, compare vs realign cycles, and the end of the
//           final pass.
// Ports   : clk_i, rst_i (sync, active-high); clr_i zero both counters;
//           load_beat_i accepted beat; pass_en_i sequencer in PASS;
//           load_last_o current beat completes the window; compare_o
//           current PASS cycle is a compare cycle; pass_end_o last cycle
//           of the final pass.
module median_seq_cnt
    import median_pkg::*;
#(
    parameter int NB_PIXEL = NB_PIXEL_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic load_beat_i,
    input  logic pass_en_i,
    output logic load_last_o,
    output logic compare_o,
    output logic pass_end_o
);

    localparam int CW = cyc_cnt_w(NB_PIXEL);
    localparam int PW = pass_cnt_w(NB_PIXEL);
    localparam logic [CW-1:0] LAST_IDX  = CW'(NB_PIXEL - 1);
    localparam logic [PW-1:0] LAST_PASS = PW'(NB_PIXEL / 2);

    logic [CW-1:0] cyc_q, cyc_d;
    logic [PW-1:0] pass_q, pass_d;
    logic [CW-1:0] n_cmp;
    logic          final_pass;

    // Pass k compares NB_PIXEL-1-k times; the rest of its cycles realign.
    assign n_cmp       = LAST_IDX - CW'(pass_q);
    assign final_pass  = (pass_q == LAST_PASS);
    assign compare_o   = (cyc_q < n_cmp);
    assign load_last_o = (cyc_q == LAST_IDX);
    assign pass_end_o  = pass_en_i && final_pass && (cyc_q == n_cmp - CW'(1));

    always_comb begin
        cyc_d  = cyc_q;
        pass_d = pass_q;
        if (clr_i) begin
            cyc_d  = '0;
            pass_d = '0;
        end else if (load_beat_i) begin
            cyc_d = load_last_o ? '0 : cyc_q + CW'(1);
        end else if (pass_en_i) begin
            if (pass_end_o) begin
                cyc_d  = '0;
                pass_d = '0;
            end else if (cyc_q == LAST_IDX) begin
                cyc_d  = '0;
                pass_d = pass_q + PW'(1);
            end else begin
                cyc_d = cyc_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cyc_q  <= '0;
            pass_q <= '0;
        end else begin
            cyc_q  <= cyc_d;
            pass_q <= pass_d;
        end
    end

endmodule

// File: rtl/median_seq.sv
// rtl/median_seq.sv - control sequencer feeding a MED median datapath
//
// Purpose : accepts NB_PIXEL pixels over a valid/ready stream, shifts them
//           into MED, runs the compare/realign passes that leave the median
//           in MED's last stage, and reports it with a one-cycle pulse.
// Ports   : CLK; RST sync active-high; PIX_IN/PIX_VALID/PIX_READY pixel
//           stream; DI/DSI/BYP/DO MED interface; MED_OUT/MED_VALID result;
//           LOAD_ERR window aborted (PIX_VALID dropped mid-load).
// Config  : MEDIAN_SEQ_RESULT_REG_EN registers MED_OUT/MED_VALID one cycle
//           after DONE; otherwise MED_OUT follows DO and MED_VALID is DONE.
module median_seq
    import median_pkg::*;
#(
    parameter int SIZE     = SIZE_DEF,
    parameter int NB_PIXEL = NB_PIXEL_DEF
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [SIZE-1:0] PIX_IN,
    input  logic            PIX_VALID,
    output logic            PIX_READY,
    output logic [SIZE-1:0] DI,
    output logic            DSI,
    output logic            BYP,
    input  logic [SIZE-1:0] DO,
    output logic [SIZE-1:0] MED_OUT,
    output logic            MED_VALID,
    output logic            LOAD_ERR
);

    logic [ST_W-1:0] state_q, state_d;
    logic            beat;
    logic            load_last;
    logic            compare;
    logic            pass_end;
    logic            cnt_clr;

    assign PIX_READY = (state_q == ST_IDLE) || (state_q == ST_LOAD);
    assign beat      = PIX_VALID && PIX_READY;
    assign DI        = PIX_IN;
    assign DSI       = (state_q != ST_PASS);
    assign BYP       = !((state_q == ST_PASS) && compare);
    assign LOAD_ERR  = (state_q == ST_LOAD) && !PIX_VALID;
    assign cnt_clr   = LOAD_ERR || (state_q == ST_DONE);

    median_seq_cnt #(
        .NB_PIXEL (NB_PIXEL)
    ) u_cnt (
        .clk_i       (CLK),
        .rst_i       (RST),
        .clr_i       (cnt_clr),
        .load_beat_i (beat),
        .pass_en_i   (state_q == ST_PASS),
        .load_last_o (load_last),
        .compare_o   (compare),
        .pass_end_o  (pass_end)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (beat) state_d = ST_LOAD;
            ST_LOAD: begin
                if (!PIX_VALID)     state_d = ST_IDLE;
                else if (load_last) state_d = ST_PASS;
            end
            ST_PASS: if (pass_end) state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

`ifdef MEDIAN_SEQ_RESULT_REG_EN
    logic [SIZE-1:0] med_out_q;
    logic            med_valid_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            med_out_q   <= '0;
            med_valid_q <= 1'b0;
        end else begin
            med_valid_q <= (state_q == ST_DONE);
            if (state_q == ST_DONE) med_out_q <= DO;
        end
    end

    assign MED_OUT   = med_out_q;
    assign MED_VALID = med_valid_q;
`else
    assign MED_OUT   = DO;
    assign MED_VALID = (state_q == ST_DONE);
`endif

endmodule
